// File: rtl/port_rd_ctrl.sv
// Per-port read-side controller: pops the dispatcher-selected queue, issues the
// packet's SRAM reads under a credit limit and streams words out with SOP/EOP framing.
module port_rd_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 14,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            queue_available,
    input  logic [2:0]            prior,
    output logic                  next,
    output logic                  pop_req,
    output logic [2:0]            pop_prior,
    input  logic                  pop_ack,
    input  logic [ADDR_WIDTH-1:0] pkt_addr,
    input  logic [8:0]            pkt_len,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sop,
    output logic                  out_eop
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_READ   = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

    state_t                  state_r, state_s;
    logic                    pop_req_r;
    logic [2:0]              pop_prior_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [8:0]              remain_r;
    logic                    first_r;
    logic                    next_r;
    // used_r counts words issued but not yet accepted downstream (in flight + buffered)
    logic [CW-1:0]           used_r;
    logic [RD_LAT-1:0]       pv_r, ps_r, pe_r;
    logic [DATA_WIDTH+1:0]   mem_r [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]           cnt_r;
    logic                    issue_s, last_s, wr_s, pop_s, valid_s;
    logic [DATA_WIDTH+1:0]   head_s;

    // Credit check and FIFO handshake decode
    always_comb begin
        issue_s = (state_r == S_READ) && (used_r < CW'(FIFO_DEPTH));
        last_s  = issue_s && (remain_r == 9'd0);
        wr_s    = pv_r[RD_LAT-1];
        valid_s = (cnt_r != {CW{1'b0}});
        pop_s   = valid_s && out_ready;
        head_s  = mem_r[rd_ptr_r];
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (queue_available[prior]) state_s = S_REQ;
                else                        state_s = S_IDLE;
            end
            S_REQ: begin
                if (pop_ack) state_s = S_READ;
                else         state_s = S_REQ;
            end
            S_READ: begin
                if (last_s) state_s = S_SETTLE;
                else        state_s = S_READ;
            end
            S_SETTLE: state_s = S_IDLE;
            default:  state_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= S_IDLE;
        else        state_r <= state_s;
    end

    // Pop handshake, address/length counters, next pulse and credit accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_req_r   <= 1'b0;
            pop_prior_r <= 3'd0;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            remain_r    <= 9'd0;
            first_r     <= 1'b0;
            next_r      <= 1'b0;
            used_r      <= {CW{1'b0}};
        end else begin
            if (state_r == S_IDLE && queue_available[prior]) begin
                pop_req_r   <= 1'b1;
                pop_prior_r <= prior;
            end else if (state_r == S_REQ && pop_ack) begin
                pop_req_r   <= 1'b0;
            end
            if (state_r == S_REQ && pop_ack) begin
                addr_r   <= pkt_addr;
                remain_r <= pkt_len;
                first_r  <= 1'b1;
            end else if (issue_s) begin
                addr_r   <= addr_r + ADDR_WIDTH'(1'b1);
                remain_r <= remain_r - 9'd1;
                first_r  <= 1'b0;
            end
            next_r <= last_s;
            used_r <= used_r + CW'(issue_s) - CW'(pop_s);
        end
    end

    // Valid/tag pipeline matching the SRAM read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_r <= {RD_LAT{1'b0}};
            ps_r <= {RD_LAT{1'b0}};
            pe_r <= {RD_LAT{1'b0}};
        end else begin
            pv_r[0] <= issue_s;
            ps_r[0] <= issue_s && first_r;
            pe_r[0] <= last_s;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_r[i] <= pv_r[i-1];
                ps_r[i] <= ps_r[i-1];
                pe_r[i] <= pe_r[i-1];
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            if (wr_s)  wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            if (pop_s) rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            cnt_r <= cnt_r + CW'(wr_s) - CW'(pop_s);
        end
    end

    // FIFO storage; contents are masked by the occupancy count so need no reset
    always_ff @(posedge clk) begin
        if (wr_s) mem_r[wr_ptr_r] <= {ps_r[RD_LAT-1], pe_r[RD_LAT-1], rd_data};
    end

    // Output drive; head entry is forced to zero while the FIFO is empty
    always_comb begin
        if (valid_s) begin
            out_data = head_s[DATA_WIDTH-1:0];
            out_eop  = head_s[DATA_WIDTH];
            out_sop  = head_s[DATA_WIDTH+1];
        end else begin
            out_data = {DATA_WIDTH{1'b0}};
            out_eop  = 1'b0;
            out_sop  = 1'b0;
        end
    end

    assign out_valid = valid_s;
    assign rd_en     = issue_s;
    assign rd_addr   = addr_r;
    assign pop_req   = pop_req_r;
    assign pop_prior = pop_prior_r;
    assign next      = next_r;

endmodule
